// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data paths
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYC > 0) ? CW'(WAIT_CYC - 1) : '0;

  state_t            state, next_state;
  logic              owner, last_owner;
  logic              pick_d, any_req, sample_rd;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_we;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  assign any_req = if_req | d_req;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    next_state = state;
    pick_d     = 1'b0;
    sample_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && d_req) pick_d = (last_owner == OWN_IF);
        else                 pick_d = d_req;
        if (any_req) next_state = ISSUE;
      end
      ISSUE: begin
        if (WAIT_CYC == 0) begin
          sample_rd  = 1'b1;
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          sample_rd  = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_IF;
      last_owner <= OWN_D;
      cnt        <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_we     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner      <= pick_d;
        last_owner <= pick_d;
        cap_addr   <= pick_d ? d_addr : if_addr;
        cap_we     <= pick_d & d_we;
        cap_wdata  <= pick_d ? d_wdata : '0;
      end
      if (state == ISSUE)     cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 1'b1;
      // Stores leave d_rdata untouched.
      if (sample_rd) begin
        if (owner == OWN_IF) if_rdata_q <= mem_rdata;
        else if (!cap_we)    d_rdata_q  <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign if_gnt    = (state == ISSUE) && (owner == OWN_IF);
  assign d_gnt     = (state == ISSUE) && (owner == OWN_D);
  assign if_done   = (state == RESP)  && (owner == OWN_IF);
  assign d_done    = (state == RESP)  && (owner == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench; instance k has WAIT_CYC=k, all share inputs
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;

  logic [3:0]  if_gnt, if_done, d_gnt, d_done, mem_en, mem_we, busy;
  logic [31:0] if_rdata [4];
  logic [31:0] d_rdata [4];
  logic [15:0] mem_addr [4];
  logic [31:0] mem_wdata [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYC(g)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]), .if_done(if_done[g]),
      .if_rdata(if_rdata[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt[g]), .d_done(d_done[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata), .busy(busy[g])
    );
  end

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        e_ig;
    logic        e_id;
    logic        e_dg;
    logic        e_dd;
    logic        e_men;
    logic        e_mwe;
    logic        e_busy;
    logic [15:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    // rst ireq iaddr dreq dwe daddr dwdata mrdata | ig id dg dd men mwe busy maddr mwdata ird drd
    tbl[0]  = '{1,0,16'h0000,0,0,16'h0000,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h0,32'h0};
    tbl[1]  = '{0,1,16'h0004,0,0,16'h0000,32'h0,32'h21051888,   1,0,0,0,1,0,1,16'h0004,32'h0,32'h0,32'h0};
    tbl[2]  = '{0,0,16'h0000,0,0,16'h0000,32'h0,32'h21051888,   0,1,0,0,0,0,1,16'h0004,32'h0,32'h21051888,32'h0};
    tbl[3]  = '{0,0,16'h0000,0,0,16'h0000,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h21051888,32'h0};
    tbl[4]  = '{0,0,16'h0000,1,0,16'h0200,32'h0,32'h0,          0,0,1,0,1,0,1,16'h0200,32'h0,32'h21051888,32'h0};
    tbl[5]  = '{0,0,16'h0000,0,0,16'h0000,32'h0,32'hCAFE0001,   0,0,0,1,0,0,1,16'h0200,32'h0,32'h21051888,32'hCAFE0001};
    tbl[6]  = '{0,0,16'h0000,1,1,16'h0300,32'h12345678,32'h0,   0,0,0,0,0,0,0,16'h0000,32'h0,32'h21051888,32'hCAFE0001};
    tbl[7]  = '{0,0,16'h0000,1,1,16'h0300,32'h12345678,32'h0,   0,0,1,0,1,1,1,16'h0300,32'h12345678,32'h21051888,32'hCAFE0001};
    tbl[8]  = '{0,0,16'h0000,0,0,16'h0000,32'h0,32'hFFFFFFFF,   0,0,0,1,0,0,1,16'h0300,32'h0,32'h21051888,32'hCAFE0001};
    tbl[9]  = '{0,0,16'h0000,0,0,16'h0000,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h21051888,32'hCAFE0001};
    tbl[10] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          1,0,0,0,1,0,1,16'h0010,32'h0,32'h21051888,32'hCAFE0001};
    tbl[11] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h00001111,   0,1,0,0,0,0,1,16'h0010,32'h0,32'h00001111,32'hCAFE0001};
    tbl[12] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h00001111,32'hCAFE0001};
    tbl[13] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          0,0,1,0,1,0,1,16'h0020,32'h0,32'h00001111,32'hCAFE0001};
    tbl[14] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h00002222,   0,0,0,1,0,0,1,16'h0020,32'h0,32'h00001111,32'h00002222};
    tbl[15] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h00001111,32'h00002222};
    tbl[16] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          1,0,0,0,1,0,1,16'h0010,32'h0,32'h00001111,32'h00002222};
    tbl[17] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h00003333,   0,1,0,0,0,0,1,16'h0010,32'h0,32'h00003333,32'h00002222};
    tbl[18] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h00003333,32'h00002222};
    tbl[19] = '{0,1,16'h0010,1,0,16'h0020,32'h0,32'h0,          0,0,1,0,1,0,1,16'h0020,32'h0,32'h00003333,32'h00002222};
    tbl[20] = '{1,0,16'h0000,0,0,16'h0000,32'h0,32'h0,          0,0,0,0,0,0,0,16'h0000,32'h0,32'h0,32'h0};

    #1;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; if_req = tbl[i].ireq; if_addr = tbl[i].iaddr;
      d_req = tbl[i].dreq; d_we = tbl[i].dwe; d_addr = tbl[i].daddr;
      d_wdata = tbl[i].dwdata; mem_rdata = tbl[i].mrdata;
      step();
      chk($sformatf("row%0d if_gnt", i),   32'(if_gnt[0]),  32'(tbl[i].e_ig));
      chk($sformatf("row%0d if_done", i),  32'(if_done[0]), 32'(tbl[i].e_id));
      chk($sformatf("row%0d d_gnt", i),    32'(d_gnt[0]),   32'(tbl[i].e_dg));
      chk($sformatf("row%0d d_done", i),   32'(d_done[0]),  32'(tbl[i].e_dd));
      chk($sformatf("row%0d mem_en", i),   32'(mem_en[0]),  32'(tbl[i].e_men));
      chk($sformatf("row%0d mem_we", i),   32'(mem_we[0]),  32'(tbl[i].e_mwe));
      chk($sformatf("row%0d busy", i),     32'(busy[0]),    32'(tbl[i].e_busy));
      chk($sformatf("row%0d if_rdata", i), if_rdata[0],     tbl[i].e_ird);
      chk($sformatf("row%0d d_rdata", i),  d_rdata[0],      tbl[i].e_drd);
      if (tbl[i].e_busy)
        chk($sformatf("row%0d mem_addr", i), 32'(mem_addr[0]), 32'(tbl[i].e_maddr));
      if (tbl[i].e_mwe)
        chk($sformatf("row%0d mem_wdata", i), mem_wdata[0], tbl[i].e_mwdata);
    end

    // WAIT_CYC=2 store: address held through WAIT, done at t+4, d_rdata untouched
    do_reset();
    d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
    step();
    chk("w2 st d_gnt", 32'(d_gnt[2]), 32'd1);
    chk("w2 st mem_we", 32'(mem_we[2]), 32'd1);
    chk("w2 st mem_wdata", mem_wdata[2], 32'hDEADBEEF);
    chk("w2 st mem_addr", 32'(mem_addr[2]), 32'h0100);
    d_req = 0; d_we = 0; d_addr = 16'h7777; d_wdata = 32'h0; mem_rdata = 32'h99999999;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("w2 st wait%0d mem_en", c), 32'(mem_en[2]), 32'd0);
      chk($sformatf("w2 st wait%0d mem_addr", c), 32'(mem_addr[2]), 32'h0100);
      chk($sformatf("w2 st wait%0d d_done", c), 32'(d_done[2]), 32'd0);
      chk($sformatf("w2 st wait%0d d_gnt", c), 32'(d_gnt[2]), 32'd0);
    end
    step();
    chk("w2 st d_done", 32'(d_done[2]), 32'd1);
    chk("w2 st d_rdata", d_rdata[2], 32'h0);
    step();
    chk("w2 st idle", 32'(busy[2]), 32'd0);

    // WAIT_CYC=1: if_req dropped after grant still completes, no regrant
    do_reset();
    if_req = 1; if_addr = 16'h0040; mem_rdata = 32'h0BADF00D;
    step();
    chk("w1 drop if_gnt", 32'(if_gnt[1]), 32'd1);
    if_req = 0;
    step();
    chk("w1 drop wait if_done", 32'(if_done[1]), 32'd0);
    step();
    chk("w1 drop if_done", 32'(if_done[1]), 32'd1);
    chk("w1 drop if_rdata", if_rdata[1], 32'h0BADF00D);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("w1 drop no regrant%0d", c), 32'(if_gnt[1] | busy[1]), 32'd0);
    end

    // WAIT_CYC=3: reset during WAIT abandons the access and restores IF priority
    do_reset();
    if_req = 1; if_addr = 16'h0080;
    step();
    chk("w3 rst if_gnt", 32'(if_gnt[3]), 32'd1);
    if_req = 0;
    step();
    step();
    chk("w3 rst in wait", 32'(busy[3] & ~mem_en[3]), 32'd1);
    rst = 1;
    step();
    chk("w3 rst busy", 32'(busy[3]), 32'd0);
    chk("w3 rst mem_en", 32'(mem_en[3]), 32'd0);
    chk("w3 rst if_done", 32'(if_done[3]), 32'd0);
    rst = 0; if_req = 1; d_req = 1; if_addr = 16'h0088; d_addr = 16'h0099;
    step();
    chk("w3 after rst if_gnt", 32'(if_gnt[3]), 32'd1);
    chk("w3 after rst d_gnt", 32'(d_gnt[3]), 32'd0);
    chk("w3 after rst mem_addr", 32'(mem_addr[3]), 32'h0088);

    // WAIT_CYC=2: d_req rising during an IF wait is held off until the next IDLE
    do_reset();
    if_req = 1; if_addr = 16'h0050;
    step();
    chk("w2 late if_gnt", 32'(if_gnt[2]), 32'd1);
    if_req = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 16'h0060;
    step();
    chk("w2 late wait d_gnt", 32'(d_gnt[2]), 32'd0);
    step();
    chk("w2 late if_done", 32'(if_done[2]), 32'd1);
    chk("w2 late resp d_gnt", 32'(d_gnt[2]), 32'd0);
    step();
    chk("w2 late idle", 32'(busy[2] | d_gnt[2]), 32'd0);
    step();
    chk("w2 late d_gnt", 32'(d_gnt[2]), 32'd1);
    chk("w2 late mem_addr", 32'(mem_addr[2]), 32'h0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: the instruction-fetch path (IF) and the load/store data path (D).
- Each access is captured, issued to memory, waited on for a fixed number of cycles, and returned with a one-cycle done pulse.
- Contention is resolved round-robin, so neither fetch nor data accesses starve.
- Sits between the CPU FSM controller and the memory (ROM/RAM).

Parameters:
- ADDR_W, 16, address width (matches PC width).
- DATA_W, 32, data width.
- WAIT_CYC, 0, extra memory latency in cycles. 0 means combinational read: data is valid in the issue cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch grant pulse
- if_done  out  1  fetch complete pulse
- if_rdata  out  DATA_W  fetch data, valid while if_done=1
- d_req  in  1  data request (level)
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data grant pulse
- d_done  out  1  data complete pulse
- d_rdata  out  DATA_W  load data, valid while d_done=1 and d_we was 0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  1 when state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, owner=IF, last_owner=D (so IF wins the first tie).
  - All gnt/done/mem_en/mem_we/busy are 0; all rdata/addr/wdata registers are 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, that requester wins.
  - If both req, the winner is the requester that is not last_owner.
  - On the leaving edge: capture the winner's addr/we/wdata (IF is always a read), set owner and last_owner to the winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we=captured we; mem_addr/mem_wdata=captured values.
  - The owner's gnt=1.
  - If WAIT_CYC=0: sample mem_rdata into the owner's rdata register, go to RESP.
  - Else: load counter=WAIT_CYC-1, go to WAIT.
- WAIT:
  - mem_en=0; mem_addr held stable.
  - Counter decrements each cycle.
  - When counter=0: sample mem_rdata, go to RESP.
- RESP (exactly 1 cycle):
  - The owner's done=1; the owner's rdata is valid.
  - Stores also pulse done. d_rdata is left unchanged on a store.
  - Always go to IDLE.
- Latency: request high in IDLE cycle t gives gnt in cycle t+1 and done in cycle t+2+WAIT_CYC.
  - Throughput is one access per 3+WAIT_CYC cycles.
- gnt and done are single-cycle pulses, decoded from registered state and owner. They are never both asserted in the same cycle.
- Requests:
  - Only sampled in IDLE. A req that rises in ISSUE/WAIT/RESP waits for the next IDLE.
  - A req that drops after grant does not cancel the access; it completes normally.
  - A req still high in IDLE after that requester's RESP counts as a new request and is arbitrated normally.
  - Requesters hold addr/wdata stable only until gnt. Values are captured at the IDLE exit edge.
- Outputs are registered or decoded from registers; there is no combinational path from req to gnt or mem_en.
- rst mid-transaction: the access is abandoned, no done pulse is issued, and state returns to reset values on the next edge.
- Non-owner gnt/done stay 0 throughout a transaction.

Test Plan:
- WAIT_CYC=0; if_req=1, if_addr=0x0004, mem_rdata=0x2105_1888 → if_gnt at t+1 with mem_en=1 and mem_addr=0x0004; if_done at t+2 with if_rdata=0x2105_1888.
- WAIT_CYC=2; d_req=1, d_we=1, d_addr=0x0100, d_wdata=0xDEAD_BEEF → d_gnt at t+1 with mem_we=1 and mem_wdata=0xDEAD_BEEF; mem_addr held through WAIT; d_done at t+4; d_rdata unchanged.
- WAIT_CYC=0; both req held high continuously after reset → grant order IF, D, IF, D; each done arrives 1 cycle after its gnt; busy drops for exactly 1 IDLE cycle between accesses.
- if_req drops in the cycle after if_gnt, with WAIT_CYC=1 → access completes; if_done at t+3; no second grant.
- rst asserted in WAIT (WAIT_CYC=3) → no done pulse; next cycle busy=0 and mem_en=0; with both reqs high afterwards, IF wins first.
- d_req rises during an IF transaction's WAIT → no d_gnt until the IDLE after if_done; then d_gnt follows 1 cycle later.
